// File: rtl/im_loader.sv
// im_loader: byte-stream program loader for the instruction memory.
// Optional checksum phase enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h00003000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] len_words,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [10:0] LP_DEPTH = 11'(DEPTH);

    state_t      r_state;
    logic [10:0] r_len;
    logic [10:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_buf;
    logic        r_in_ready;
    logic        r_im_we;
    logic [31:0] r_im_addr;
    logic [31:0] r_im_wdata;
    logic        r_busy;
    logic        r_done;

    logic [10:0] w_len;
    logic        w_accept;
    logic [31:0] w_word;
    logic        w_last;

    assign w_len    = (len_words > LP_DEPTH) ? LP_DEPTH : len_words;
    assign w_accept = in_valid & r_in_ready;
    assign w_word   = {r_buf, in_data};
    assign w_last   = (r_word_idx == r_len - 11'd1);

`ifdef IM_LOADER_CHECKSUM_EN
    logic        r_err;
    logic [31:0] r_csum;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign in_ready = r_in_ready;
    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign busy     = r_busy;
    assign cpu_hold = r_busy;
    assign done     = r_done;

    // Load sequencer: byte assembly, word writes, optional checksum, done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_buf      <= '0;
            r_in_ready <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= BASE_ADDR;
            r_im_wdata <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_err      <= 1'b0;
            r_csum     <= '0;
`endif
        end else if (abort) begin
            // Partial word is dropped; words already written stay in IM
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_in_ready <= 1'b0;
            r_im_we    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len      <= w_len;
                        r_word_idx <= '0;
                        r_byte_cnt <= '0;
                        r_busy     <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
                        r_err      <= 1'b0;
                        r_csum     <= '0;
`endif
                        if (w_len == 11'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_RECV;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_buf      <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state    <= S_WRITE;
                            r_in_ready <= 1'b0;
                            r_im_we    <= 1'b1;
                            r_im_addr  <= BASE_ADDR
                                          + {19'd0, r_word_idx, 2'b00};
                            r_im_wdata <= w_word;
`ifdef IM_LOADER_CHECKSUM_EN
                            r_csum     <= r_csum ^ w_word;
`endif
                        end
                    end
                end
                S_WRITE: begin
                    r_im_we    <= 1'b0;
                    r_word_idx <= r_word_idx + 11'd1;
                    if (w_last) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        r_state    <= S_CHECK;
                        r_in_ready <= 1'b1;
`else
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
`endif
                    end else begin
                        r_state    <= S_RECV;
                        r_in_ready <= 1'b1;
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        r_buf      <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_err      <= (w_word != r_csum);
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_im_we    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
